// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles big-endian words from a length-prefixed,
// XOR-checksummed stream and writes them into instruction memory, gating core reset.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StChk, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] ww_q, ww_d;

  logic        accept;
  logic [15:0] len_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ww_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      ww_q       <= ww_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    ww_d       = ww_q;

    in_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
               (state_q == StData)  || (state_q == StChk);
    accept   = in_valid && in_ready;
    len_full = {count_q[15:8], in_data};

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenHi;
          done_d     = 1'b0;
          error_d    = 1'b0;
          ww_d       = '0;
          chk_d      = '0;
          byte_idx_d = '0;
          hold_d     = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StLenHi: begin
        if (accept) begin
          count_d[15:8] = in_data;
          chk_d         = chk_q ^ in_data;
          state_d       = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          count_d = len_full;
          chk_d   = chk_q ^ in_data;
          if ({16'h0000, len_full} > MAX_WORDS) begin
            state_d = StErr;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (len_full == 16'h0000) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          word_d     = {word_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Registered strobe gives the fixed one-cycle write latency.
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'b0, ww_q, 2'b00};
            wdata_d = {word_q, in_data};
            ww_d    = ww_q + 16'd1;
            if (ww_q + 16'd1 == count_q) state_d = StChk;
          end
        end
      end
      StChk: begin
        if (accept) begin
          busy_d = 1'b0;
          if (in_data == chk_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart of the instruction memory read path: receives a program as a byte stream and writes it, one 32-bit word at a time, into the instruction memory write port.
- Holds the processor in reset (cpu_hold) until a complete, checksum-valid image has been written.
- Sits between the external byte source (host/UART bridge) and the instruction memory and core reset.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first program word; must be word-aligned.
- MAX_WORDS, 256, largest accepted word count (instruction memory depth).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe (one-cycle pulse).
- imem_addr  out  32  byte address of the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  high = processor held in reset.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully (sticky).
- error  out  1  last load failed (sticky).
- words_written  out  16  number of words written in the current or last load.

Behaviour:
- Stream format: count_hi, count_lo (16-bit word count N, MSB first), then N words of 4 bytes each, MSB first, then 1 checksum byte.
- Checksum: XOR of every byte from count_hi through the last data byte.
- Byte transfer: a byte is accepted on a rising clk edge when in_valid=1 and in_ready=1. in_ready is a function of state only: 1 in LEN_HI, LEN_LO, DATA, CHK; 0 elsewhere.
- Reset (rst=0, asynchronous), all outputs and state:
  - state=IDLE
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, busy=0, done=0, error=0, words_written=0
  - Internal byte index, word counter and checksum cleared.
- States:
  - IDLE/DONE/ERR, start=1: go to LEN_HI. Clear done, error, words_written and checksum. Set cpu_hold=1, busy=1.
  - LEN_HI, byte accepted: count[15:8]=byte, go to LEN_LO.
  - LEN_LO, byte accepted: count[7:0]=byte. Then:
    - if count>MAX_WORDS, go to ERR;
    - else if count==0, go to CHK;
    - else go to DATA.
  - DATA, byte accepted: shift the byte into the word assembly register and increment the byte index (mod 4).
    - On the 4th byte: in the next cycle, imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*k (k = word index from 0), imem_wdata=assembled word, words_written increments.
    - After the byte completing word N-1, go to CHK.
  - CHK, byte accepted: byte==checksum, go to DONE; otherwise go to ERR.
  - DONE: done=1, busy=0, cpu_hold=0.
  - ERR: error=1, busy=0, cpu_hold=1.
- start is ignored while busy=1.
- Write latency: exactly 1 cycle from acceptance of the 4th byte of a word to the imem_we pulse.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Address arithmetic is 32-bit and wraps modulo 2^32; no overflow detection.
- Words already written before an ERR are not undone. cpu_hold stays 1 until a later load succeeds.
- in_valid may drop between bytes for any number of cycles; the stall has no effect on state.
- rst asserted mid-load: immediate return to IDLE with the reset values above. Any pending write is dropped (imem_we=0). Memory contents are untouched.
- After reset, cpu_hold stays 1 until the first successful load.

Test Plan:
1. start, then bytes 00 02 20 08 00 05 AC 08 00 00 8B -> imem_we pulses twice: (BASE_ADDR, 0x20080005) and (BASE_ADDR+4, 0xAC080000), each 1 cycle after its 4th byte. Then done=1, cpu_hold=0, words_written=2, busy=0.
2. Same stream with checksum byte 8A -> both writes still occur; error=1, done=0, cpu_hold=1.
3. Bytes 00 00 00 (N=0) -> no imem_we; done=1, cpu_hold=0, words_written=0.
4. Bytes 01 01 with MAX_WORDS=256 -> ERR right after count_lo; in_ready=0, no writes, error=1.
5. Test 1 stream with random 0-5 cycle in_valid gaps, plus start pulsed mid-load -> results identical to test 1; the extra start has no effect.
6. rst=0 asserted after byte 5 of test 1 -> immediately state IDLE, imem_we=0, cpu_hold=1, words_written=0. A new start plus the full test 1 stream then succeeds.
